// File: rtl/fetch_sequencer.sv
// Fetch/run-control unit: PC sequencing with req/done handshake, writable branch LUT and stall.
// Optional return stack enabled by defining FETCH_CALL_STACK_EN.
module fetch_sequencer #(
    parameter int unsigned D        = 12,
    parameter int unsigned LT       = 5,
    parameter int unsigned END_ADDR = 128,
    parameter int unsigned SD       = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          done,
    output logic [D-1:0]  prog_ctr,
    output logic          fetch_valid,
    input  logic          stall,
    input  logic          br_take,
    input  logic          br_rel,
    input  logic [LT-1:0] br_idx,
    input  logic          lut_wr_en,
    input  logic [LT-1:0] lut_wr_idx,
    input  logic [D-1:0]  lut_wr_data
`ifdef FETCH_CALL_STACK_EN
    ,
    input  logic          call,
    input  logic          ret,
    output logic          stack_err
`endif
);

    localparam int unsigned LUT_N  = 2 ** LT;
    localparam logic [D-1:0] END_PC = D'(END_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [D-1:0]   prog_ctr_q, prog_ctr_d;
    logic           fetch_valid_q, fetch_valid_d;
    logic           done_q, done_d;
    logic [D-1:0]   lut_q [LUT_N];

    logic           at_end;
    logic           advance;
    logic [D-1:0]   lut_rd;
    logic [D-1:0]   pc_inc;
    logic [D-1:0]   br_target;
    logic           pop_sel;
    logic [D-1:0]   pop_pc;

    assign at_end    = (prog_ctr_q == END_PC);
    assign advance   = (state_q == ST_RUN) && !at_end && !stall;
    assign lut_rd    = lut_q[br_idx];
    assign pc_inc    = prog_ctr_q + D'(1);
    // Relative targets: the D-bit LUT word is already the sign-extended offset modulo 2**D.
    assign br_target = br_rel ? (prog_ctr_q + lut_rd) : lut_rd;

    // Branch-target LUT: synchronous write, combinational read (same-cycle read sees old word).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(LUT_N); i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_wr_en) begin
            lut_q[lut_wr_idx] <= lut_wr_data;
        end
    end

`ifdef FETCH_CALL_STACK_EN
    localparam int unsigned SPW = $clog2(SD + 1);
    localparam int unsigned SIW = (SD > 1) ? $clog2(SD) : 1;

    logic [D-1:0]   stk_q [SD];
    logic [SPW-1:0] sp_q, sp_d;
    logic [SPW-1:0] sp_m1;
    logic           stack_err_q, stack_err_d;
    logic           do_call, do_ret, stk_full, stk_empty, push_ok;

    assign do_call   = advance && call && br_take;
    assign do_ret    = advance && ret && !call;
    assign stk_full  = (sp_q == SPW'(SD));
    assign stk_empty = (sp_q == '0);
    assign push_ok   = do_call && !stk_full;
    assign sp_m1     = sp_q - SPW'(1);
    assign pop_sel   = do_ret;
    assign pop_pc    = stk_empty ? pc_inc : stk_q[sp_m1[SIW-1:0]];

    // Stack pointer and sticky error; both cleared when a new run begins.
    always_comb begin
        sp_d        = sp_q;
        stack_err_d = stack_err_q;
        if (state_q == ST_IDLE && state_d == ST_RUN) begin
            sp_d = '0;
        end else if (push_ok) begin
            sp_d = sp_q + SPW'(1);
        end else if (do_ret && !stk_empty) begin
            sp_d = sp_m1;
        end
        if (state_d == ST_IDLE) begin
            stack_err_d = 1'b0;
        end
        if ((do_call && stk_full) || (do_ret && stk_empty)) begin
            stack_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q        <= '0;
            stack_err_q <= 1'b0;
            for (int i = 0; i < int'(SD); i++) begin
                stk_q[i] <= '0;
            end
        end else begin
            sp_q        <= sp_d;
            stack_err_q <= stack_err_d;
            if (push_ok) begin
                stk_q[sp_q[SIW-1:0]] <= pc_inc;
            end
        end
    end

    assign stack_err = stack_err_q;
`else
    assign pop_sel = 1'b0;
    assign pop_pc  = '0;
`endif

    // State register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            prog_ctr_q    <= '0;
            fetch_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            prog_ctr_q    <= prog_ctr_d;
            fetch_valid_q <= fetch_valid_d;
            done_q        <= done_d;
        end
    end

    // Next-state logic; req is only sampled in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req)    state_d = ST_RUN;
            ST_RUN:  if (at_end) state_d = ST_DONE;
            ST_DONE: if (!req)   state_d = ST_IDLE;
            default:             state_d = ST_IDLE;
        endcase
    end

    // PC update in priority order end > stall > return > branch > increment.
    always_comb begin
        prog_ctr_d    = prog_ctr_q;
        fetch_valid_d = (state_d == ST_RUN);
        done_d        = (state_d == ST_DONE);
        unique case (state_q)
            ST_IDLE: prog_ctr_d = '0;
            ST_RUN: begin
                if (advance) begin
                    if (pop_sel) begin
                        prog_ctr_d = pop_pc;
                    end else if (br_take) begin
                        prog_ctr_d = br_target;
                    end else begin
                        prog_ctr_d = pc_inc;
                    end
                end
            end
            ST_DONE: prog_ctr_d = prog_ctr_q;
            default: prog_ctr_d = '0;
        endcase
    end

    assign prog_ctr    = prog_ctr_q;
    assign fetch_valid = fetch_valid_q;
    assign done        = done_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer (default build): directed scenarios plus randomized traffic
// checked every cycle against a run-mode/PC/LUT model.
module tb_fetch_sequencer;

    localparam int D       = 12;
    localparam int LT      = 5;
    localparam int END_PC  = 128;
    localparam int MOD     = 4096;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DONE  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          done;
    logic [D-1:0]  prog_ctr;
    logic          fetch_valid;
    logic          stall;
    logic          br_take;
    logic          br_rel;
    logic [LT-1:0] br_idx;
    logic          lut_wr_en;
    logic [LT-1:0] lut_wr_idx;
    logic [D-1:0]  lut_wr_data;

    int n_tests = 0;
    int n_fail  = 0;

    int m_mode;
    int m_pc;
    int m_lut [32];

    always #5 clk = ~clk;

    fetch_sequencer #(.D(D), .LT(LT), .END_ADDR(END_PC), .SD(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .prog_ctr    (prog_ctr),
        .fetch_valid (fetch_valid),
        .stall       (stall),
        .br_take     (br_take),
        .br_rel      (br_rel),
        .br_idx      (br_idx),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_idx  (lut_wr_idx),
        .lut_wr_data (lut_wr_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_pc   = 0;
        for (int i = 0; i < 32; i++) m_lut[i] = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs currently applied.
    task automatic model_edge();
        case (m_mode)
            M_IDLE: begin
                m_pc = 0;
                if (req) m_mode = M_RUN;
            end
            M_RUN: begin
                if (m_pc == END_PC) m_mode = M_DONE;
                else if (stall) m_pc = m_pc;
                else if (br_take) m_pc = br_rel ? (m_pc + m_lut[br_idx]) % MOD : m_lut[br_idx];
                else m_pc = (m_pc + 1) % MOD;
            end
            default: if (!req) m_mode = M_IDLE;
        endcase
        if (lut_wr_en) m_lut[lut_wr_idx] = int'(lut_wr_data);
    endtask

    task automatic compare();
        chk("done", 32'(done), 32'(m_mode == M_DONE));
        chk("fetch_valid", 32'(fetch_valid), 32'(m_mode == M_RUN));
        if (m_mode != M_IDLE) chk("prog_ctr", 32'(prog_ctr), 32'(m_pc));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic run_until_pc(input int target, input int budget);
        int k = 0;
        while (!(m_mode == M_RUN && m_pc == target) && k < budget) begin
            step();
            k++;
        end
        chk("reach_pc", 32'(prog_ctr), 32'(target));
    endtask

    task automatic run_until_done(input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    task automatic async_reset_pulse();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int nvalid;
        reset = 1'b0; req = 1'b0; stall = 1'b0; br_take = 1'b0; br_rel = 1'b0;
        br_idx = '0; lut_wr_en = 1'b0; lut_wr_idx = '0; lut_wr_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", 32'(prog_ctr), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fv", 32'(fetch_valid), 32'd0);
        reset = 1'b1;
        step();
        step();

        // Reset while running at pc=37 clears outputs without waiting for a clock.
        req = 1'b1;
        step();
        chk("start_pc", 32'(prog_ctr), 32'd0);
        chk("start_fv", 32'(fetch_valid), 32'd1);
        run_until_pc(37, 100);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_pc", 32'(prog_ctr), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_fv", 32'(fetch_valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        req = 1'b0;
        step();
        step();

        // Straight-line run 0..128, done held while req stays high.
        req = 1'b1;
        step();
        nvalid = int'(fetch_valid);
        for (int k = 0; k < 300 && done !== 1'b1; k++) begin
            step();
            nvalid += int'(fetch_valid);
        end
        chk("done_after_run", 32'(done), 32'd1);
        chk("end_pc", 32'(prog_ctr), 32'd128);
        chk("fetch_count", 32'(nvalid), 32'd129);
        repeat (3) step();
        chk("done_held", 32'(done), 32'd1);
        req = 1'b0;
        step();
        chk("done_clear", 32'(done), 32'd0);
        chk("idle_fv", 32'(fetch_valid), 32'd0);

        // Relative backward and absolute branches, then wrap through 0xFFF.
        lut_wr_en = 1'b1; lut_wr_idx = 5'd3; lut_wr_data = 12'hFFE;
        step();
        lut_wr_en = 1'b0;
        req = 1'b1;
        step();
        req = 1'b0;
        run_until_pc(20, 50);
        br_take = 1'b1; br_rel = 1'b1; br_idx = 5'd3;
        step();
        chk("rel_back", 32'(prog_ctr), 32'd18);
        br_rel = 1'b0;
        step();
        chk("abs_ffe", 32'(prog_ctr), 32'hFFE);
        br_take = 1'b0;
        step();
        chk("inc_fff", 32'(prog_ctr), 32'hFFF);
        step();
        chk("wrap_0", 32'(prog_ctr), 32'd0);
        run_until_done(300);
        step();
        chk("back_idle", 32'(done), 32'd0);

        // Stall beats branch; then LUT write/read same cycle; then branch landing on END.
        req = 1'b1;
        step();
        req = 1'b0;
        run_until_pc(10, 50);
        stall = 1'b1; br_take = 1'b1; br_rel = 1'b0; br_idx = 5'd3;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_hold", 32'(prog_ctr), 32'd10);
        end
        stall = 1'b0; br_take = 1'b0;
        step();
        chk("stall_release", 32'(prog_ctr), 32'd11);
        lut_wr_en = 1'b1; lut_wr_idx = 5'd5; lut_wr_data = 12'd40;
        br_take = 1'b1; br_idx = 5'd5;
        step();
        chk("lut_old_read", 32'(prog_ctr), 32'd0);
        lut_wr_en = 1'b0;
        step();
        chk("lut_new_read", 32'(prog_ctr), 32'd40);
        br_take = 1'b0;
        lut_wr_en = 1'b1; lut_wr_idx = 5'd7; lut_wr_data = 12'd128;
        step();
        lut_wr_en = 1'b0;
        br_take = 1'b1; br_idx = 5'd7;
        step();
        chk("land_end", 32'(prog_ctr), 32'd128);
        br_take = 1'b0;
        step();
        chk("land_done", 32'(done), 32'd1);
        chk("land_pc_hold", 32'(prog_ctr), 32'd128);
        step();

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 4000; c++) begin
            req       = 1'($urandom % 2);
            stall     = ($urandom % 4) == 0;
            br_take   = ($urandom % 6) == 0;
            br_rel    = 1'($urandom % 2);
            br_idx    = LT'($urandom % 32);
            lut_wr_en = ($urandom % 5) == 0;
            lut_wr_idx = LT'($urandom % 32);
            case ($urandom % 4)
                0: lut_wr_data = D'($urandom % MOD);
                1: lut_wr_data = D'(128);
                2: lut_wr_data = D'((MOD + int'($urandom % 17) - 8) % MOD);
                default: lut_wr_data = D'(120);
            endcase
            step();
            if ($urandom % 500 == 0) async_reset_pulse();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
